// File: rtl/loader_pkg.sv
// Shared state encoding and widths for prog_loader.
// The ERR state is only present when PROG_LOADER_TIMEOUT_EN is defined.
package loader_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned NIB_W  = 4;

`ifdef PROG_LOADER_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;
`endif

endpackage

// File: rtl/prog_loader.sv
// Keypad program loader: shifts four hex nibbles into a word and writes it to instruction memory.
// Define PROG_LOADER_TIMEOUT_EN to add an ack timeout that drops the request and latches o_error.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_strobe,
  input  logic [NIB_W-1:0]  i_nibble,
  input  logic              i_mode,
  input  logic              i_wr_ack,
  output logic              o_wr_req,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [WORD_W-1:0] o_wr_data,
  output logic [WORD_W-1:0] o_entry,
  output logic [1:0]        o_digit,
  output logic              o_wrapped,
  output logic              o_error
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_data;
  logic [WORD_W-1:0] r_entry;
  logic [1:0]        r_digit;
  logic              r_wrapped;

  logic              w_enter;
  logic              w_drop;
  logic              w_shift;
  logic              w_ack;
  logic [WORD_W-1:0] w_entry_shift;

  assign w_entry_shift = {r_entry[WORD_W-NIB_W-1:0], i_nibble};

`ifdef PROG_LOADER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_error;
  logic             w_timeout;

  // Fires on the WAIT_MAX-th unacknowledged WRITE cycle, so o_wr_req is high exactly WAIT_MAX cycles.
  assign w_timeout = (r_wait_cnt == CNT_W'(WAIT_MAX - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
      r_error    <= 1'b0;
    end else if (r_state == WRITE && !i_wr_ack) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_timeout) r_error <= 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign o_error = r_error;
`else
  logic w_unused_wait_max;
  assign w_unused_wait_max = (WAIT_MAX == 0);
  assign o_error           = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_mode) w_next = COLLECT;
      COLLECT: begin
        if (!i_mode)                         w_next = IDLE;
        else if (i_strobe && r_digit == 2'd3) w_next = WRITE;
      end
      WRITE: begin
        if (i_wr_ack)       w_next = i_mode ? COLLECT : IDLE;
`ifdef PROG_LOADER_TIMEOUT_EN
        else if (w_timeout) w_next = ERR;
`endif
      end
`ifdef PROG_LOADER_TIMEOUT_EN
      ERR:     if (!i_mode) w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  // Strobes are only decoded in COLLECT, which also drops a strobe coincident with an ack.
  always_comb begin
    o_wr_req = 1'b0;
    w_enter  = 1'b0;
    w_drop   = 1'b0;
    w_shift  = 1'b0;
    w_ack    = 1'b0;
    case (r_state)
      IDLE:    w_enter = i_mode;
      COLLECT: begin
        w_drop  = !i_mode;
        w_shift = i_mode && i_strobe;
      end
      WRITE: begin
        o_wr_req = 1'b1;
        w_ack    = i_wr_ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr    <= '0;
      r_data    <= '0;
      r_entry   <= '0;
      r_digit   <= '0;
      r_wrapped <= 1'b0;
    end else begin
      if (w_enter) begin
        r_addr    <= '0;
        r_entry   <= '0;
        r_digit   <= '0;
        r_wrapped <= 1'b0;
      end
      if (w_drop) begin
        r_entry <= '0;
        r_digit <= '0;
      end
      if (w_shift) begin
        r_entry <= w_entry_shift;
        r_digit <= r_digit + 2'd1;
        if (r_digit == 2'd3) r_data <= w_entry_shift;
      end
      if (w_ack) begin
        r_addr  <= r_addr + 1'b1;
        r_entry <= '0;
        if (&r_addr) r_wrapped <= 1'b1;
      end
    end
  end

  assign o_wr_addr = r_addr;
  assign o_wr_data = r_data;
  assign o_entry   = r_entry;
  assign o_digit   = r_digit;
  assign o_wrapped = r_wrapped;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader (ADDR_W=2 so address wrap is reachable quickly).
// Covers the PROG_LOADER_TIMEOUT_EN build when that macro is defined for the bench too.
module tb_prog_loader;

  localparam int unsigned AW = 2;
  localparam int unsigned WM = 15;
  localparam int unsigned NADDR = 1 << AW;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic          strobe = 1'b0;
  logic [3:0]    nibble = 4'h0;
  logic          mode   = 1'b0;
  logic          wr_ack = 1'b0;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [15:0]   entry;
  logic [1:0]    digit;
  logic          wrapped;
  logic          error;

  // {wr_req, wr_addr, wr_data, entry, digit, wrapped}
  logic [37:0]   obs;
  assign obs = {wr_req, wr_addr, wr_data, entry, digit, wrapped};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(AW), .WAIT_MAX(WM)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_strobe  (strobe),
    .i_nibble  (nibble),
    .i_mode    (mode),
    .i_wr_ack  (wr_ack),
    .o_wr_req  (wr_req),
    .o_wr_addr (wr_addr),
    .o_wr_data (wr_data),
    .o_entry   (entry),
    .o_digit   (digit),
    .o_wrapped (wrapped),
    .o_error   (error)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_nib(input logic [3:0] n);
    nibble = n;
    strobe = 1'b1;
    cyc();
    strobe = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int k = 0; k < 4; k++) send_nib(4'((w >> (12 - 4 * k)) & 16'hF));
  endtask

  task automatic restart();
    mode = 1'b0;
    cyc();
    mode = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({obs, error} !== 39'd0) begin
      errors++; $display("FAIL reset_async got %h want 0", {obs, error});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checks++;
    if ({obs, error} !== 39'd0) begin
      errors++; $display("FAIL reset_idle got %h want 0", {obs, error});
    end
  endtask

  task automatic test_basic();
    logic [37:0] exp;
    restart();
    send_nib(4'h1);
    send_nib(4'h2);
    checks++;
    if ({wr_req, entry, digit} !== {1'b0, 16'h0012, 2'd2}) begin
      errors++; $display("FAIL basic_partial got %h want %h", {wr_req, entry, digit}, {1'b0, 16'h0012, 2'd2});
    end
    send_nib(4'h3);
    send_nib(4'h4);
    exp = {1'b1, 2'd0, 16'h1234, 16'h1234, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL basic_word got %h want %h", obs, exp);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({wr_req, wr_addr, wr_data} !== {1'b1, 2'd0, 16'h1234}) begin
        errors++; $display("FAIL basic_hold%0d got %h want %h", i, {wr_req, wr_addr, wr_data}, {1'b1, 2'd0, 16'h1234});
      end
    end
    wr_ack = 1'b1;
    cyc();
    wr_ack = 1'b0;
    exp = {1'b0, 2'd1, 16'h1234, 16'h0000, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL basic_ack got %h want %h", obs, exp);
    end
  endtask

  task automatic test_abort();
    logic [37:0] exp;
    send_nib(4'hA);
    send_nib(4'hB);
    checks++;
    if ({entry, digit} !== {16'h00AB, 2'd2}) begin
      errors++; $display("FAIL abort_partial got %h want %h", {entry, digit}, {16'h00AB, 2'd2});
    end
    mode = 1'b0;
    cyc();
    exp = {1'b0, 2'd1, 16'h1234, 16'h0000, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL abort_drop got %h want %h", obs, exp);
    end
    send_nib(4'hC);
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL abort_idle_strobe got %h want %h", obs, exp);
    end
    mode = 1'b1;
    cyc();
    exp = {1'b0, 2'd0, 16'h1234, 16'h0000, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++; $display("FAIL abort_reenter got %h want %h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    w = 16'($urandom);
    send_word(w);
    nibble = 4'hF;
    strobe = 1'b1;
    wr_ack = 1'b1;
    cyc();
    strobe = 1'b0;
    wr_ack = 1'b0;
    checks++;
    if (obs !== {1'b0, 2'd1, w, 16'h0000, 2'd0, 1'b0}) begin
      errors++; $display("FAIL coincident_ack got %h want %h", obs, {1'b0, 2'd1, w, 16'h0000, 2'd0, 1'b0});
    end
    send_nib(4'h7);
    checks++;
    if ({entry, digit} !== {16'h0007, 2'd1}) begin
      errors++; $display("FAIL coincident_next got %h want %h", {entry, digit}, {16'h0007, 2'd1});
    end
  endtask

  task automatic test_random();
    int          exp_addr;
    logic        exp_wrapped;
    logic [15:0] w;
    logic [15:0] exp_entry;
    restart();
    exp_addr    = 0;
    exp_wrapped = 1'b0;
    for (int n = 0; n < 12; n++) begin
      w = 16'($urandom);
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 2)) begin
          wr_ack = 1'($urandom_range(0, 1));
          nibble = 4'($urandom);
          cyc();
        end
        wr_ack = 1'b0;
        send_nib(4'((w >> (12 - 4 * k)) & 16'hF));
        if (k < 3) begin
          exp_entry = w >> (12 - 4 * k);
          checks++;
          if ({wr_req, entry, digit} !== {1'b0, exp_entry, 2'(k + 1)}) begin
            errors++; $display("FAIL rand_entry w%0d k%0d got %h want %h", n, k, {wr_req, entry, digit}, {1'b0, exp_entry, 2'(k + 1)});
          end
        end
      end
      checks++;
      if (obs !== {1'b1, AW'(exp_addr), w, w, 2'd0, exp_wrapped}) begin
        errors++; $display("FAIL rand_req w%0d got %h want %h", n, obs, {1'b1, AW'(exp_addr), w, w, 2'd0, exp_wrapped});
      end
      repeat ($urandom_range(0, 4)) begin
        strobe = 1'($urandom_range(0, 1));
        nibble = 4'($urandom);
        cyc();
        strobe = 1'b0;
        checks++;
        if ({wr_req, wr_addr, wr_data, digit} !== {1'b1, AW'(exp_addr), w, 2'd0}) begin
          errors++; $display("FAIL rand_hold w%0d got %h want %h", n, {wr_req, wr_addr, wr_data, digit}, {1'b1, AW'(exp_addr), w, 2'd0});
        end
      end
      strobe = 1'($urandom_range(0, 1));
      wr_ack = 1'b1;
      cyc();
      strobe = 1'b0;
      wr_ack = 1'b0;
      exp_addr = (exp_addr + 1) % NADDR;
      if (exp_addr == 0) exp_wrapped = 1'b1;
      checks++;
      if (obs !== {1'b0, AW'(exp_addr), w, 16'h0000, 2'd0, exp_wrapped}) begin
        errors++; $display("FAIL rand_ack w%0d got %h want %h", n, obs, {1'b0, AW'(exp_addr), w, 16'h0000, 2'd0, exp_wrapped});
      end
    end
  endtask

  task automatic test_wrap();
    restart();
    for (int n = 0; n < 5; n++) begin
      send_word(16'hA000 + 16'(n));
      checks++;
      if ({wr_req, wr_addr, wr_data} !== {1'b1, AW'(n % NADDR), 16'hA000 + 16'(n)}) begin
        errors++; $display("FAIL wrap_req w%0d got %h want %h", n, {wr_req, wr_addr, wr_data}, {1'b1, AW'(n % NADDR), 16'hA000 + 16'(n)});
      end
      wr_ack = 1'b1;
      cyc();
      wr_ack = 1'b0;
      checks++;
      if ({wr_req, wr_addr, wrapped} !== {1'b0, AW'((n + 1) % NADDR), (n >= 3) ? 1'b1 : 1'b0}) begin
        errors++; $display("FAIL wrap_ack w%0d got %h want %h", n, {wr_req, wr_addr, wrapped}, {1'b0, AW'((n + 1) % NADDR), (n >= 3) ? 1'b1 : 1'b0});
      end
    end
    restart();
    checks++;
    if ({wr_addr, wrapped} !== {AW'(0), 1'b0}) begin
      errors++; $display("FAIL wrap_clear got %h want 0", {wr_addr, wrapped});
    end
  endtask

  task automatic test_reset_mid_write();
    send_word(16'h5A5A);
    checks++;
    if (wr_req !== 1'b1) begin
      errors++; $display("FAIL rstw_req got %b want 1", wr_req);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({obs, error} !== 39'd0) begin
      errors++; $display("FAIL rstw_async got %h want 0", {obs, error});
    end
    @(negedge clk);
    rst_n  = 1'b1;
    wr_ack = 1'b1;
    cyc();
    wr_ack = 1'b0;
    checks++;
    if ({obs, error} !== 39'd0) begin
      errors++; $display("FAIL rstw_late_ack got %h want 0", {obs, error});
    end
  endtask

  task automatic test_timeout();
    int n;
    restart();
    send_word(16'hBEEF);
`ifdef PROG_LOADER_TIMEOUT_EN
    n = 0;
    while (wr_req === 1'b1 && n < 40) begin
      n++;
      cyc();
    end
    checks++;
    if (n != WM) begin
      errors++; $display("FAIL timeout_len got %0d want %0d", n, WM);
    end
    checks++;
    if ({wr_req, error} !== 2'b01) begin
      errors++; $display("FAIL timeout_err got %b want 01", {wr_req, error});
    end
    send_nib(4'h3);
    checks++;
    if ({wr_req, digit, error} !== {1'b0, 2'd0, 1'b1}) begin
      errors++; $display("FAIL timeout_err_strobe got %h want %h", {wr_req, digit, error}, {1'b0, 2'd0, 1'b1});
    end
    mode = 1'b0;
    cyc();
    mode = 1'b1;
    cyc();
    send_nib(4'h6);
    checks++;
    if ({wr_req, entry, digit, error} !== {1'b0, 16'h0006, 2'd1, 1'b1}) begin
      errors++; $display("FAIL timeout_sticky got %h want %h", {wr_req, entry, digit, error}, {1'b0, 16'h0006, 2'd1, 1'b1});
    end
`else
    n = 0;
    repeat (40) begin
      cyc();
      if (wr_req === 1'b1) n++;
    end
    checks++;
    if ({n, error} !== {32'd40, 1'b0}) begin
      errors++; $display("FAIL no_timeout got req_cycles=%0d err=%b want 40 0", n, error);
    end
    wr_ack = 1'b1;
    cyc();
    wr_ack = 1'b0;
    checks++;
    if ({wr_req, wr_addr, error} !== {1'b0, AW'(1), 1'b0}) begin
      errors++; $display("FAIL no_timeout_ack got %h want %h", {wr_req, wr_addr, error}, {1'b0, AW'(1), 1'b0});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_back_to_back();
    test_random();
    test_wrap();
    test_reset_mid_write();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
